// File: rtl/sargantana_icache_pkg.sv
// Shared widths, width-derivation helpers and response layout for the i-cache hit checker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sargantana_icache_pkg;

    localparam int DEF_N_WAY   = 4;
    localparam int DEF_TAG_W   = 20;
    localparam int DEF_LINE_W  = 512;
    localparam int DEF_FETCH_W = 128;
    localparam int DEF_CNT_W   = 32;

    // Chunk index width; a single-chunk line still gets a 1-bit index port.
    function automatic int calc_idx_w(input int n_chunk);
        return (n_chunk <= 1) ? 1 : $clog2(n_chunk);
    endfunction

    // Way index width; degenerate single-way caches keep a 1-bit way field.
    function automatic int calc_way_w(input int n_way);
        return (n_way <= 1) ? 1 : $clog2(n_way);
    endfunction

    // Response view at the default geometry, for consumers on the fetch path.
    typedef struct packed {
        logic                        hit;
        logic                        multihit;
        logic [$clog2(DEF_N_WAY)-1:0] way;
        logic [DEF_FETCH_W-1:0]      data;
    } icache_rsp_t;

endpackage

// File: rtl/sargantana_icache_chunk_sel.sv
// Selects one FETCH_WIDTH chunk out of a cache line; out-of-range index falls back to chunk 0.
// Latency: combinational.
// Backpressure: none (pure mux).
module sargantana_icache_chunk_sel #(
    parameter int LINE_WIDTH  = 512,
    parameter int FETCH_WIDTH = 128,
    parameter int IDX_W       = 2
) (
    input  logic [LINE_WIDTH-1:0]  line_i,
    input  logic [IDX_W-1:0]       idx_i,
    output logic [FETCH_WIDTH-1:0] chunk_o
);

    localparam int N_CHUNK = LINE_WIDTH / FETCH_WIDTH;

    // Chunk 0 is the default so indices beyond the last chunk never select garbage.
    always_comb begin
        chunk_o = line_i[FETCH_WIDTH-1:0];
        for (int c = 0; c < N_CHUNK; c++) begin
            if (idx_i == IDX_W'(c)) begin
                chunk_o = line_i[c*FETCH_WIDTH +: FETCH_WIDTH];
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_checker_pipe.sv
// Two-stage i-cache hit checker: S1 tag compare + per-way chunk pick, S2 lowest-way select.
// Latency: 2 cycles from request accept to rsp_valid_o; sustains 1 response per cycle.
// Backpressure: rsp_ready_i low stalls S2, then S1; req_ready_o drops once both stages hold data.
module sargantana_icache_checker_pipe
    import sargantana_icache_pkg::*;
#(
    parameter int ICACHE_N_WAY = DEF_N_WAY,
    parameter int TAG_WIDTH    = DEF_TAG_W,
    parameter int LINE_WIDTH   = DEF_LINE_W,
    parameter int FETCH_WIDTH  = DEF_FETCH_W,
    parameter int CNT_WIDTH    = DEF_CNT_W,
    localparam int N_CHUNK     = LINE_WIDTH / FETCH_WIDTH,
    localparam int IDX_W       = calc_idx_w(N_CHUNK),
    localparam int WAY_W       = calc_way_w(ICACHE_N_WAY)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [TAG_WIDTH-1:0]               tag_i,
    input  logic [IDX_W-1:0]                   fetch_idx_i,
    input  logic [ICACHE_N_WAY-1:0]            way_valid_bits_i,
    input  logic [ICACHE_N_WAY*TAG_WIDTH-1:0]  read_tags_i,
    input  logic [ICACHE_N_WAY*LINE_WIDTH-1:0] data_rd_i,
    output logic                               rsp_valid_o,
    input  logic                               rsp_ready_i,
    output logic                               rsp_hit_o,
    output logic [WAY_W-1:0]                   rsp_way_o,
    output logic [FETCH_WIDTH-1:0]             rsp_data_o,
    output logic                               rsp_multihit_o,
    output logic                               err_o,
    output logic [CNT_WIDTH-1:0]               hit_cnt_o,
    output logic [CNT_WIDTH-1:0]               miss_cnt_o
);

    typedef struct packed {
        logic                   hit;
        logic                   multihit;
        logic [WAY_W-1:0]       way;
        logic [FETCH_WIDTH-1:0] data;
    } rsp_t;

    logic [ICACHE_N_WAY-1:0]             hit_vec;
    logic [ICACHE_N_WAY*FETCH_WIDTH-1:0] chunk_vec;

    logic                                s1_valid_q, s1_valid_d;
    logic [ICACHE_N_WAY-1:0]             s1_hit_q, s1_hit_d;
    logic [ICACHE_N_WAY*FETCH_WIDTH-1:0] s1_chunk_q, s1_chunk_d;

    logic                                s2_valid_q, s2_valid_d;
    rsp_t                                rsp_q, rsp_d, rsp_enc;

    logic [CNT_WIDTH-1:0]                hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]                miss_cnt_q, miss_cnt_d;
    logic                                err_q, err_d;

    logic                                s2_adv;
    logic                                rsp_fire;
    logic [WAY_W:0]                      hit_pop;

    // Per-way tag match and chunk extraction feeding S1.
    for (genvar w = 0; w < ICACHE_N_WAY; w++) begin : g_way
        assign hit_vec[w] = way_valid_bits_i[w] &
                            (read_tags_i[w*TAG_WIDTH +: TAG_WIDTH] == tag_i);

        sargantana_icache_chunk_sel #(
            .LINE_WIDTH  (LINE_WIDTH),
            .FETCH_WIDTH (FETCH_WIDTH),
            .IDX_W       (IDX_W)
        ) u_chunk_sel (
            .line_i  (data_rd_i[w*LINE_WIDTH +: LINE_WIDTH]),
            .idx_i   (fetch_idx_i),
            .chunk_o (chunk_vec[w*FETCH_WIDTH +: FETCH_WIDTH])
        );
    end

    assign s2_adv      = !s2_valid_q | rsp_ready_i;
    assign req_ready_o = !rst_i & (!s1_valid_q | s2_adv);
    assign rsp_fire    = s2_valid_q & rsp_ready_i;

    // Lowest hitting way wins: scan from the top so lower ways overwrite; popcount flags multi-hit.
    always_comb begin
        rsp_enc = '0;
        hit_pop = '0;
        for (int w = ICACHE_N_WAY - 1; w >= 0; w--) begin
            if (s1_hit_q[w]) begin
                rsp_enc.hit  = 1'b1;
                rsp_enc.way  = WAY_W'(w);
                rsp_enc.data = s1_chunk_q[w*FETCH_WIDTH +: FETCH_WIDTH];
            end
        end
        for (int w = 0; w < ICACHE_N_WAY; w++) begin
            hit_pop = hit_pop + (WAY_W+1)'(s1_hit_q[w]);
        end
        rsp_enc.multihit = (hit_pop > (WAY_W+1)'(1));
    end

    // Pipeline advance: S1 refills whenever it can hand off, S2 loads whenever its slot frees; flush wins.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_hit_d   = s1_hit_q;
        s1_chunk_d = s1_chunk_q;
        s2_valid_d = s2_valid_q;
        rsp_d      = rsp_q;
        if (req_ready_o) begin
            s1_valid_d = req_valid_i;
            if (req_valid_i) begin
                s1_hit_d   = hit_vec;
                s1_chunk_d = chunk_vec;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_d = rsp_enc;
            end
        end
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Saturating perf counters and sticky multi-hit error, all keyed on the response handshake.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = err_q;
        if (rsp_fire) begin
            if (rsp_q.hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            end
            if (rsp_q.multihit) err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            s1_chunk_q <= '0;
            s2_valid_q <= 1'b0;
            rsp_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_chunk_q <= s1_chunk_d;
            s2_valid_q <= s2_valid_d;
            rsp_q      <= rsp_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
        end
    end

    assign rsp_valid_o    = s2_valid_q;
    assign rsp_hit_o      = rsp_q.hit;
    assign rsp_way_o      = rsp_q.way;
    assign rsp_data_o     = rsp_q.data;
    assign rsp_multihit_o = rsp_q.multihit;
    assign err_o          = err_q;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// Scoreboard bench for the i-cache hit checker: directed requests push expectations,
// a negedge monitor pops and compares on every presented response.
// Counter width is shrunk to 4 so saturation is reachable in a short run.
module tb_sargantana_icache_checker_pipe;

    localparam int NW = 4;
    localparam int TW = 20;
    localparam int LW = 512;
    localparam int FW = 128;
    localparam int CW = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [TW-1:0]    tag_i;
    logic [1:0]       fetch_idx_i;
    logic [NW-1:0]    way_valid_bits_i;
    logic [NW*TW-1:0] read_tags_i;
    logic [NW*LW-1:0] data_rd_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_hit_o;
    logic [1:0]       rsp_way_o;
    logic [FW-1:0]    rsp_data_o;
    logic             rsp_multihit_o;
    logic             err_o;
    logic [CW-1:0]    hit_cnt_o;
    logic [CW-1:0]    miss_cnt_o;

    typedef struct packed {
        logic          hit;
        logic          mh;
        logic [1:0]    way;
        logic [FW-1:0] data;
    } exp_t;

    exp_t          q[$];
    exp_t          exp_pending;
    int            n_cmp  = 0;
    int            n_bad  = 0;
    int            hs_cnt = 0;
    int            base;
    logic [CW-1:0] m_hit  = '0;
    logic [CW-1:0] m_miss = '0;
    logic          m_err  = 1'b0;

    always #5 clk_i = ~clk_i;

    sargantana_icache_checker_pipe #(
        .ICACHE_N_WAY (NW),
        .TAG_WIDTH    (TW),
        .LINE_WIDTH   (LW),
        .FETCH_WIDTH  (FW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .tag_i            (tag_i),
        .fetch_idx_i      (fetch_idx_i),
        .way_valid_bits_i (way_valid_bits_i),
        .read_tags_i      (read_tags_i),
        .data_rd_i        (data_rd_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_hit_o        (rsp_hit_o),
        .rsp_way_o        (rsp_way_o),
        .rsp_data_o       (rsp_data_o),
        .rsp_multihit_o   (rsp_multihit_o),
        .err_o            (err_o),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    function automatic logic [FW-1:0] mk_chunk(input int w, input int c, input logic [15:0] s);
        return {16'hCAFE, s, 32'(w), 32'(c), 32'h0BADF00D};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [TW-1:0] tag, input logic [1:0] idx, input logic [3:0] vb,
                           input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                           input logic [TW-1:0] t2, input logic [TW-1:0] t3,
                           input logic [15:0] s, input logic eh, input logic [1:0] ew,
                           input logic emh);
        tag_i            = tag;
        fetch_idx_i      = idx;
        way_valid_bits_i = vb;
        read_tags_i      = {t3, t2, t1, t0};
        for (int w = 0; w < NW; w++) begin
            for (int c = 0; c < LW / FW; c++) begin
                data_rd_i[w*LW + c*FW +: FW] = mk_chunk(w, c, s);
            end
        end
        exp_pending.hit  = eh;
        exp_pending.mh   = emh;
        exp_pending.way  = ew;
        exp_pending.data = eh ? mk_chunk(int'(ew), int'(idx), s) : '0;
        req_valid_i      = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            if (req_ready_o && !flush_i) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk_i);
            #1;
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: accepted=0 required=1 within 20 cycles", name);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic issue(input string name, input logic [TW-1:0] tag, input logic [1:0] idx,
                         input logic [3:0] vb, input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                         input logic [TW-1:0] t2, input logic [TW-1:0] t3, input logic [15:0] s,
                         input logic eh, input logic [1:0] ew, input logic emh);
        set_req(tag, idx, vb, t0, t1, t2, t3, s, eh, ew, emh);
        wait_accept(name);
    endtask

    // Monitor: counters vs model, response vs queue head, then queue maintenance.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                q.delete();
                m_hit  = '0;
                m_miss = '0;
                m_err  = 1'b0;
            end else begin
                chk("hit_cnt_model", 128'(hit_cnt_o), 128'(m_hit));
                chk("miss_cnt_model", 128'(miss_cnt_o), 128'(m_miss));
                chk("err_model", 128'(err_o), 128'(m_err));
                if (rsp_valid_o) begin
                    chk("rsp_has_expect", 128'(q.size() != 0), 128'(1));
                    if (q.size() != 0) begin
                        chk("rsp_hit", 128'(rsp_hit_o), 128'(q[0].hit));
                        chk("rsp_way", 128'(rsp_way_o), 128'(q[0].way));
                        chk("rsp_multihit", 128'(rsp_multihit_o), 128'(q[0].mh));
                        chk("rsp_data", 128'(rsp_data_o), 128'(q[0].data));
                        if (rsp_ready_i) begin
                            if (q[0].hit) begin
                                if (m_hit != '1) m_hit = m_hit + CW'(1);
                            end else begin
                                if (m_miss != '1) m_miss = m_miss + CW'(1);
                            end
                            if (q[0].mh) m_err = 1'b1;
                            void'(q.pop_front());
                            hs_cnt++;
                        end
                    end
                end
                if (flush_i) q.delete();
                if (req_valid_i && req_ready_o && !flush_i) q.push_back(exp_pending);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i            = 1'b1;
        flush_i          = 1'b0;
        req_valid_i      = 1'b0;
        rsp_ready_i      = 1'b1;
        tag_i            = '0;
        fetch_idx_i      = '0;
        way_valid_bits_i = '0;
        read_tags_i      = '0;
        data_rd_i        = '0;
        exp_pending      = '0;

        // Reset state.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", 128'(req_ready_o), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        chk("rst_rsp_hit", 128'(rsp_hit_o), 128'(0));
        chk("rst_rsp_data", 128'(rsp_data_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_hit_cnt", 128'(hit_cnt_o), 128'(0));
        chk("rst_miss_cnt", 128'(miss_cnt_o), 128'(0));
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", 128'(req_ready_o), 128'(1));
        @(posedge clk_i);
        #1;

        // Way 2 hit, chunk 3 = line2[511:384], two-cycle latency.
        issue("t1_hit", 20'h12345, 2'd3, 4'b1111, 20'h00001, 20'h00002, 20'h12345, 20'h00004,
              16'h0001, 1'b1, 2'd2, 1'b0);
        @(negedge clk_i);
        chk("t1_lat_first_edge", 128'(rsp_valid_o), 128'(0));
        @(negedge clk_i);
        chk("t1_lat_second_edge", 128'(rsp_valid_o), 128'(1));
        @(negedge clk_i);
        chk("t1_hit_cnt", 128'(hit_cnt_o), 128'(1));

        // Tag matches way 1 but its valid bit is clear: miss.
        @(posedge clk_i);
        #1;
        issue("t2_invalid_way", 20'h0ABCD, 2'd1, 4'b1101, 20'h00011, 20'h0ABCD, 20'h00013, 20'h00014,
              16'h0002, 1'b0, 2'd0, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("t2_miss_cnt", 128'(miss_cnt_o), 128'(1));

        // Ways 1 and 3 both hit: lowest way, multihit, sticky error.
        @(posedge clk_i);
        #1;
        issue("t3_multihit", 20'h55555, 2'd1, 4'b1111, 20'h00021, 20'h55555, 20'h00023, 20'h55555,
              16'h0003, 1'b1, 2'd1, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("t3_err_set", 128'(err_o), 128'(1));
        @(posedge clk_i);
        #1;
        issue("t3_plain_hit", 20'h00033, 2'd0, 4'b1111, 20'h00033, 20'h00031, 20'h00032, 20'h00034,
              16'h0004, 1'b1, 2'd0, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("t3_err_sticky", 128'(err_o), 128'(1));

        // Backpressure: two accepted, third stalls, then 4 responses back-to-back.
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        issue("bp_a", 20'h00AAA, 2'd0, 4'b0001, 20'h00AAA, 20'h00041, 20'h00042, 20'h00043,
              16'h0010, 1'b1, 2'd0, 1'b0);
        issue("bp_b", 20'h00BBB, 2'd2, 4'b0000, 20'h00BBB, 20'h00BBB, 20'h00BBB, 20'h00BBB,
              16'h0011, 1'b0, 2'd0, 1'b0);
        set_req(20'h0CCCC, 2'd1, 4'b1000, 20'h00051, 20'h00052, 20'h00053, 20'h0CCCC,
                16'h0012, 1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_req_ready_low", 128'(req_ready_o), 128'(0));
            chk("bp_rsp_held", 128'(rsp_valid_o), 128'(1));
        end
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        base = hs_cnt;
        wait_accept("bp_c");
        issue("bp_d", 20'h0DDDD, 2'd2, 4'b0101, 20'h0DDDD, 20'h00061, 20'h0DDDD, 20'h00063,
              16'h0013, 1'b1, 2'd0, 1'b1);
        repeat (2) @(negedge clk_i);
        #1;
        chk("bp_one_per_cycle", 128'(hs_cnt - base), 128'(4));

        // Flush with two in flight: head drains in the flush cycle, rest and new request dropped.
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        issue("fl_x", 20'h00E01, 2'd0, 4'b1111, 20'h00E01, 20'h00071, 20'h00072, 20'h00073,
              16'h0020, 1'b1, 2'd0, 1'b0);
        issue("fl_y", 20'h00E02, 2'd1, 4'b1111, 20'h00081, 20'h00E02, 20'h00082, 20'h00083,
              16'h0021, 1'b1, 2'd1, 1'b0);
        set_req(20'h00E03, 2'd2, 4'b1111, 20'h00091, 20'h00092, 20'h00E03, 20'h00093,
                16'h0022, 1'b1, 2'd2, 1'b0);
        flush_i     = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("fl_no_rsp", 128'(rsp_valid_o), 128'(0));
        chk("fl_ready_next", 128'(req_ready_o), 128'(1));
        chk("fl_hit_cnt", 128'(hit_cnt_o), 128'(7));
        chk("fl_miss_cnt", 128'(miss_cnt_o), 128'(2));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("fl_stays_empty", 128'(rsp_valid_o), 128'(0));
        end

        // Reset mid-stream clears everything including the sticky error.
        @(posedge clk_i);
        #1;
        issue("rst_mid", 20'h00F01, 2'd0, 4'b1111, 20'h00F01, 20'h000A1, 20'h000A2, 20'h000A3,
              16'h0030, 1'b1, 2'd0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rm_no_rsp", 128'(rsp_valid_o), 128'(0));
        end
        chk("rm_err_clear", 128'(err_o), 128'(0));
        chk("rm_hit_cnt", 128'(hit_cnt_o), 128'(0));
        chk("rm_miss_cnt", 128'(miss_cnt_o), 128'(0));

        // 20 back-to-back hits saturate the 4-bit hit counter at 15.
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 20; i++) begin
            issue("sat_hit", 20'h10000 + 20'(i % 4), 2'(i % 4), 4'b1111,
                  20'h10000, 20'h10001, 20'h10002, 20'h10003,
                  16'(16'h0100 + i), 1'b1, 2'(i % 4), 1'b0);
        end
        repeat (3) @(negedge clk_i);
        chk("sat_hit_cnt", 128'(hit_cnt_o), 128'(15));
        chk("sat_miss_cnt", 128'(miss_cnt_o), 128'(0));
        chk("queue_drained", 128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
